dmem_mc: RTL and testbench

- Parametrised multi-cycle data memory, successor to the fixed 4-cycle data RAM of the pipelined MIPS core.
- Adds programmable access latency, an explicit Req/Ready handshake with transaction capture, byte-enable writes, back-to-back issue and a Busy flag.
- Keeps the combinational debug read port for testbench and display inspection.
- Sits in the MEM stage; the pipeline stalls while Busy=1.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_mc.sv | 101 ++++++++++
 tb/tb_dmem_mc.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data memory.
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int LAT_MAX = 15;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  // Expand byte enables to a 32-bit lane mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
endpackage

// File: rtl/dmem_array.sv
// 2**WIDTH x 32 RAM: sync byte-enable write, sync clear, two async read ports.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             en,
  input  logic [WIDTH-1:0] idx,
  input  logic [3:0]       be,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  input  logic [WIDTH-1:0] dbg_idx,
  output logic [31:0]      dbg_rd
);
  logic [31:0] mem [2**WIDTH];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < 2**WIDTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[idx] <= (mem[idx] & ~be_mask(be)) | (wd & be_mask(be));
    end
  end

  assign rd     = mem[idx];
  assign dbg_rd = mem[dbg_idx];
endmodule

// File: rtl/dmem_mc.sv
// Multi-cycle data memory: Req/Ready handshake, programmable latency, byte-enable writes.
module dmem_mc
  import dmem_pkg::*;
#(
  parameter int WIDTH   = 7,
  parameter int LATENCY = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Req,
  input  logic             WE,
  input  logic [3:0]       BE,
  input  logic [31:0]      A,
  input  logic [31:0]      WD,
  output logic             Ready,
  output logic [31:0]      RD,
  output logic             Busy,
  input  logic [WIDTH-1:0] ReadAddr,
  output logic [31:0]      Data
);
  typedef struct packed {
    logic             we;
    logic [3:0]       be;
    logic [WIDTH-1:0] idx;
    logic [31:0]      wd;
  } req_t;

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  req_t             cap, live, cur;
  logic             take, fire;
  logic [31:0]      rdata;
  logic             unused_abits;

  // Address bits outside the word index alias by design.
  assign unused_abits = ^{A[31:WIDTH+2], A[1:0]};

  assign live = '{we: WE, be: BE, idx: A[WIDTH+1:2], wd: WD};
  assign take = (state != WAIT) && Req;

  // Unreachable 2'b11 falls into the default arm and behaves like IDLE.
  always_comb begin
    nxt  = state;
    fire = 1'b0;
    cur  = cap;
    case (state)
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          nxt  = DONE;
          fire = 1'b1;
        end
      end
      default: begin
        nxt = IDLE;
        if (Req) begin
          if (LATENCY == 1) begin
            // Single-cycle build completes on the capture edge itself.
            nxt  = DONE;
            fire = 1'b1;
            cur  = live;
          end else begin
            nxt = WAIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= '0;
      RD    <= '0;
    end else begin
      state <= nxt;
      RD    <= (fire && !cur.we) ? rdata : '0;
      if (take) begin
        cap <= live;
        cnt <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign Ready = (state == DONE);
  assign Busy  = (state == WAIT);

  dmem_array #(.WIDTH(WIDTH)) u_array (
    .CLK     (CLK),
    .Reset   (Reset),
    .en      (fire && cur.we),
    .idx     (cur.idx),
    .be      (cur.be),
    .wd      (cur.wd),
    .rd      (rdata),
    .dbg_idx (ReadAddr),
    .dbg_rd  (Data)
  );
endmodule

// File: tb/tb_dmem_mc.sv
// Directed bench for dmem_mc: LATENCY=4 and LATENCY=1 instances side by side.
module tb_dmem_mc;
  logic        CLK = 1'b0;
  logic        Reset;
  int          n_chk = 0;
  int          n_pass = 0;

  logic        req4, we4, ready4, busy4;
  logic [3:0]  be4;
  logic [31:0] a4, wd4, rd4, data4;
  logic [6:0]  raddr4;

  logic        req1, we1, ready1, busy1;
  logic [3:0]  be1;
  logic [31:0] a1, wd1, rd1, data1;
  logic [6:0]  raddr1;

  always #5 CLK = ~CLK;

  dmem_mc #(.WIDTH(7), .LATENCY(4)) u4 (
    .CLK(CLK), .Reset(Reset), .Req(req4), .WE(we4), .BE(be4), .A(a4), .WD(wd4),
    .Ready(ready4), .RD(rd4), .Busy(busy4), .ReadAddr(raddr4), .Data(data4)
  );

  dmem_mc #(.WIDTH(7), .LATENCY(1)) u1 (
    .CLK(CLK), .Reset(Reset), .Req(req1), .WE(we1), .BE(be1), .A(a1), .WD(wd1),
    .Ready(ready1), .RD(rd1), .Busy(busy1), .ReadAddr(raddr1), .Data(data1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One LATENCY=4 access; A/WD/WE are scrambled while waiting to prove they are ignored.
  task automatic txn4(input logic we, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic [31:0] data_pre);
    @(negedge CLK);
    req4 = 1'b1; we4 = we; be4 = be; a4 = a; wd4 = wd;
    @(negedge CLK);
    req4 = 1'b0; a4 = 32'h0000_0010; wd4 = 32'hFFFF_FFFF; we4 = ~we;
    data_pre = '0;
    for (int i = 0; i < 3; i++) begin
      chk("busy_wait", {31'b0, busy4}, 32'd1);
      chk("ready_wait", {31'b0, ready4}, 32'd0);
      if (i == 2) data_pre = data4;
      @(negedge CLK);
    end
    chk("ready_done", {31'b0, ready4}, 32'd1);
    chk("busy_done", {31'b0, busy4}, 32'd0);
    rd = rd4;
  endtask

  logic [31:0] rd, dpre;
  logic [31:0] wv [3];

  initial begin
    Reset = 1'b1;
    req4 = 0; we4 = 0; be4 = 0; a4 = 0; wd4 = 0; raddr4 = 7'd8;
    req1 = 0; we1 = 0; be1 = 0; a1 = 0; wd1 = 0; raddr1 = 7'd1;
    repeat (2) @(negedge CLK);
    chk("rst_ready", {31'b0, ready4}, 32'd0);
    chk("rst_busy", {31'b0, busy4}, 32'd0);
    chk("rst_rd", rd4, 32'd0);
    chk("rst_data", data4, 32'd0);
    Reset = 1'b0;

    txn4(1'b0, 4'hF, 32'h10, 32'h0, rd, dpre);
    chk("rd_0x10", rd, 32'h0);

    txn4(1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF, rd, dpre);
    chk("wr_rd_zero", rd, 32'h0);
    chk("data_pre_wr", dpre, 32'h0);
    chk("data_at_ready", data4, 32'hDEAD_BEEF);
    @(negedge CLK);
    chk("ready_drop", {31'b0, ready4}, 32'd0);
    chk("rd_drop", rd4, 32'h0);

    txn4(1'b0, 4'hF, 32'h20, 32'h0, rd, dpre);
    chk("rd_0x20", rd, 32'hDEAD_BEEF);
    @(negedge CLK);
    chk("rd_cleared", rd4, 32'h0);

    txn4(1'b1, 4'b0101, 32'h20, 32'h1122_3344, rd, dpre);
    txn4(1'b0, 4'h0, 32'h20, 32'h0, rd, dpre);
    chk("rd_be0101", rd, 32'hDE22_BE44);

    txn4(1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF, rd, dpre);
    txn4(1'b0, 4'hF, 32'h20, 32'h0, rd, dpre);
    chk("rd_be0000", rd, 32'hDE22_BE44);

    // Req held high: completions every 4 cycles with no idle cycle between.
    @(negedge CLK);
    req4 = 1'b1; we4 = 1'b0; be4 = 4'hF; a4 = 32'h20;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      chk("b2b_ready", {31'b0, ready4}, (k % 4 == 0) ? 32'd1 : 32'd0);
      chk("b2b_busy", {31'b0, busy4}, (k % 4 == 0) ? 32'd0 : 32'd1);
      chk("b2b_rd", rd4, (k % 4 == 0) ? 32'hDE22_BE44 : 32'h0);
      a4 = (k % 4 == 0) ? 32'h20 : 32'h10;
      if (k == 12) req4 = 1'b0;
    end
    @(negedge CLK);
    chk("b2b_end", {31'b0, ready4}, 32'd0);

    // Reset during the WAIT of a write aborts it.
    raddr4 = 7'd12;
    @(negedge CLK);
    req4 = 1'b1; we4 = 1'b1; be4 = 4'hF; a4 = 32'h30; wd4 = 32'hAAAA_5555;
    @(negedge CLK);
    req4 = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    chk("abort_busy", {31'b0, busy4}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_ready", {31'b0, ready4}, 32'd0);
      @(negedge CLK);
    end
    chk("abort_ram12", data4, 32'h0);

    txn4(1'b1, 4'hF, 32'h230, 32'h1234_5678, rd, dpre);
    chk("alias_data12", data4, 32'h1234_5678);
    txn4(1'b0, 4'hF, 32'h30, 32'h0, rd, dpre);
    chk("alias_rd", rd, 32'h1234_5678);

    // LATENCY=1: alternating write/read to 0x04 every cycle.
    wv[0] = 32'hCAFE_0001; wv[1] = 32'h0BAD_F00D; wv[2] = 32'h5A5A_A5A5;
    @(negedge CLK);
    for (int k = 0; k < 6; k++) begin
      req1 = 1'b1; we1 = (k % 2 == 0); be1 = 4'hF; a1 = 32'h04; wd1 = wv[k / 2];
      @(negedge CLK);
      chk("l1_ready", {31'b0, ready1}, 32'd1);
      chk("l1_busy", {31'b0, busy1}, 32'd0);
      chk("l1_rd", rd1, (k % 2 == 0) ? 32'h0 : wv[k / 2]);
    end
    req1 = 1'b0;
    @(negedge CLK);
    chk("l1_idle", {31'b0, ready1}, 32'd0);
    chk("l1_data", data1, 32'h5A5A_A5A5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
